rgb_contrast_pipe: RTL and testbench
====================================

Name: rgb_contrast_pipe

Overview:
Streaming, parametrised successor to the combinational per-pixel contrast stage. It applies a three-segment piecewise-linear transfer curve independently to each of NumChannels colour channels of DataWidth bits. It has a 2-stage pipeline with a valid/ready handshake on both sides, and runtime-programmable thresholds, bases and gains. New configuration is double-buffered and takes effect only at a start-of-frame beat. It sits in the pixel pipeline between the pixel source and the display/output formatter.

Parameters:
DataWidth, 8, bits per channel sample
NumChannels, 3, channels per pixel beat (R, G, B order from LSB)
GainWidth, 8, unsigned gain width
FracBits, 4, fractional bits of gain (gain value = gain/2^FracBits)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  1 = adjust, 0 = bypass; sampled per accepted beat
in_valid_i  in  1  input beat valid
in_ready_o  out  1  block can accept beat
in_sof_i  in  1  beat is first pixel of a frame
in_pix_i  in  NumChannels*DataWidth  channel c at [c*DataWidth +: DataWidth]
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream accepts
out_sof_o  out  1  sof carried with the beat
out_pix_o  out  NumChannels*DataWidth  adjusted pixel
cfg_we_i  in  1  write shadow configuration
cfg_i  in  cfg_t  thr1, thr2, base0..2 (DataWidth each), gain0..2 (GainWidth each)
cfg_pending_o  out  1  shadow written but not yet applied

Behaviour:
- Reset: all valids 0, out_pix_o 0, out_sof_o 0, cfg_pending_o 0, in_ready_o 1. Shadow and active cfg load the defaults: thr1=85, thr2=170, base={0,42,213}, gain={8,32,8}. These reproduce the legacy curve at 8 bit.
- Handshake: a beat transfers when valid && ready on that side. Valid and data are held stable until accepted. There is no combinational path from in_valid_i to out_valid_o.
- Pipeline: S1 register and S2 (output) register.
  - in_ready_o = !s1_valid || s1_advance.
  - s1_advance = !s2_valid || out_ready_i.
  - Latency is 2 cycles with no stall. Sustained throughput is 1 beat/cycle.
  - On stall, both stages hold and no beat is dropped or duplicated.
- S1, per channel:
  - seg = 0 if x<thr1; else seg = 1 if x<thr2; else seg = 2. This is priority order: if thr1>thr2, segment 1 is never selected.
  - Register seg, d = x - thr_seg (thr_0 = 0, so d ≥ 0 always), the en flag, the sof flag, and the raw x.
- S2, per channel:
  - y = base_seg + ((d * gain_seg) >> FracBits).
  - The product is DataWidth+GainWidth bits and the sum is one bit wider.
  - Saturate y to 2^DataWidth-1. There is no wrap-around.
  - If the beat's en = 0, output raw x.
- Config:
  - cfg_we_i writes the shadow and sets cfg_pending_o.
  - An accepted beat with in_sof_i=1 copies shadow→active and clears pending. That beat and all later beats use the new active configuration; earlier beats still in the pipeline keep the config sampled at their S1.
  - Active config is captured per beat into S1 (seg base/gain registered alongside), so mid-pipeline changes cannot corrupt in-flight beats.
  - If cfg_we_i and an accepted sof beat occur in the same cycle, the sof beat applies the old shadow, the shadow takes the new value, and pending stays 1.
- Reset mid-operation flushes both stages (valids 0) and restores the defaults. Reset has priority over all other inputs.

Decomposition:
- Package rgb_contrast_pkg holds:
  - cfg_t packed struct (parametrised via package localparams DataWidth/GainWidth defaults);
  - seg_e enum {SEG_LOW, SEG_MID, SEG_HIGH};
  - the default cfg constant.
- Sub-module contrast_lane: one channel's S1 compare/subtract and S2 multiply/shift/add/saturate datapath. It takes a stage-enable input and is instantiated NumChannels times via generate.
- The top holds the valid/ready control, the sof/en pipeline and the shadow/active config registers.

Test Plan:
- Defaults, en=1, out_ready=1, channel values 0, 84, 85, 169, 170, 255 → outputs 0, 42, 42, 210, 213, 255 exactly 2 cycles after acceptance.
- en=0, pixel {R=17, G=200, B=99} → out_pix unchanged after 2 cycles; toggle en per beat → each beat follows its own en.
- Saturation: cfg gain2=255, base2=250, x=255 → 255, never wraps to a small value; thr1=200 > thr2=100, x=150 → segment 0 result.
- Backpressure: stream 20 beats with out_ready_i random 50% → output sequence identical and in order, no drops or duplicates; in_ready_o low only when both stages are full and out_ready_i=0.
- Config: write cfg (base0=100, gain0=0) mid-frame → pending=1, x=10 still gives 5; next sof beat gives 100 and pending=0; cfg_we_i in the same cycle as the sof beat → that beat uses the prior shadow and pending stays 1.
- Reset asserted with both stages full → next cycle out_valid_o=0, in_ready_o=1, cfg back to defaults (x=85 → 42).

Source files
------------

// File: rtl/rgb_contrast_pkg.sv
// Shared types and constants for the RGB contrast pipeline.
//   cfg_t       : thresholds, per-segment bases and gains for the transfer curve
//   seg_e       : curve segment selected for a sample
//   CfgDefault  : reset configuration, reproduces the legacy 8-bit curve
package rgb_contrast_pkg;

    localparam int unsigned CfgDataWidth = 8;
    localparam int unsigned CfgGainWidth = 8;

    typedef struct packed {
        logic [CfgDataWidth-1:0] thr1;
        logic [CfgDataWidth-1:0] thr2;
        logic [CfgDataWidth-1:0] base0;
        logic [CfgDataWidth-1:0] base1;
        logic [CfgDataWidth-1:0] base2;
        logic [CfgGainWidth-1:0] gain0;
        logic [CfgGainWidth-1:0] gain1;
        logic [CfgGainWidth-1:0] gain2;
    } cfg_t;

    typedef enum logic [1:0] {
        SEG_LOW,
        SEG_MID,
        SEG_HIGH
    } seg_e;

    localparam cfg_t CfgDefault = '{
        thr1:  CfgDataWidth'(85),
        thr2:  CfgDataWidth'(170),
        base0: CfgDataWidth'(0),
        base1: CfgDataWidth'(42),
        base2: CfgDataWidth'(213),
        gain0: CfgGainWidth'(8),
        gain1: CfgGainWidth'(32),
        gain2: CfgGainWidth'(8)
    };

endpackage

// File: rtl/rgb_contrast_pipe_lane.sv
// One colour channel of the contrast pipeline.
//   S1: segment select, offset from segment threshold, capture of that
//       segment's base/gain and of the raw sample.
//   S2: multiply, shift, add base, saturate; raw sample on bypass.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   s1_load_i, s2_load_i  stage enables from the top-level handshake
//   en_i                  adjust flag of the beat held in S1
//   x_i                   incoming sample
//   thr*/base*/gain*_i    configuration chosen for the incoming beat
//   y_o                   registered output sample
module contrast_lane
    import rgb_contrast_pkg::*;
#(
    parameter int unsigned DataWidth = CfgDataWidth,
    parameter int unsigned GainWidth = CfgGainWidth,
    parameter int unsigned FracBits  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s1_load_i,
    input  logic                 s2_load_i,
    input  logic                 en_i,
    input  logic [DataWidth-1:0] x_i,
    input  logic [DataWidth-1:0] thr1_i,
    input  logic [DataWidth-1:0] thr2_i,
    input  logic [DataWidth-1:0] base0_i,
    input  logic [DataWidth-1:0] base1_i,
    input  logic [DataWidth-1:0] base2_i,
    input  logic [GainWidth-1:0] gain0_i,
    input  logic [GainWidth-1:0] gain1_i,
    input  logic [GainWidth-1:0] gain2_i,
    output logic [DataWidth-1:0] y_o
);

    localparam int unsigned ProdWidth = DataWidth + GainWidth;
    localparam int unsigned SumWidth  = ProdWidth + 1;

    seg_e                 seg;
    logic [DataWidth-1:0] d_d, base_d;
    logic [GainWidth-1:0] gain_d;

    logic [DataWidth-1:0] d_q, x_q, base_q;
    logic [GainWidth-1:0] gain_q;
    logic [DataWidth-1:0] y_d, y_q;

    logic [ProdWidth-1:0] prod;
    logic [SumWidth-1:0]  sum;

    // Priority compare: with thr1 > thr2 the middle segment is unreachable.
    always_comb begin
        seg = SEG_HIGH;
        if (x_i < thr1_i) begin
            seg = SEG_LOW;
        end else if (x_i < thr2_i) begin
            seg = SEG_MID;
        end
    end

    always_comb begin
        d_d    = x_i;
        base_d = base0_i;
        gain_d = gain0_i;
        unique case (seg)
            SEG_LOW: begin
                d_d    = x_i;
                base_d = base0_i;
                gain_d = gain0_i;
            end
            SEG_MID: begin
                d_d    = x_i - thr1_i;
                base_d = base1_i;
                gain_d = gain1_i;
            end
            SEG_HIGH: begin
                d_d    = x_i - thr2_i;
                base_d = base2_i;
                gain_d = gain2_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        prod = ProdWidth'(d_q) * ProdWidth'(gain_q);
        sum  = SumWidth'(base_q) + SumWidth'(prod >> FracBits);
        y_d  = x_q;
        if (en_i) begin
            y_d = (|sum[SumWidth-1:DataWidth]) ? {DataWidth{1'b1}} : sum[DataWidth-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q    <= '0;
            x_q    <= '0;
            base_q <= '0;
            gain_q <= '0;
            y_q    <= '0;
        end else begin
            if (s1_load_i) begin
                d_q    <= d_d;
                x_q    <= x_i;
                base_q <= base_d;
                gain_q <= gain_d;
            end
            if (s2_load_i) begin
                y_q <= y_d;
            end
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/rgb_contrast_pipe.sv
// Two-stage streaming contrast adjust with valid/ready on both sides.
// Each channel runs a three-segment piecewise-linear curve (contrast_lane).
// Configuration is written into a shadow copy and promoted to the active
// copy by the next accepted start-of-frame beat, which already uses it.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   en_i                                adjust (1) or bypass (0), per beat
//   in_valid_i/in_ready_o/in_sof_i/in_pix_i     upstream beat
//   out_valid_o/out_ready_i/out_sof_o/out_pix_o downstream beat
//   cfg_we_i, cfg_i                     shadow configuration write
//   cfg_pending_o                       shadow written, not yet applied
module rgb_contrast_pipe
    import rgb_contrast_pkg::*;
#(
    parameter int unsigned DataWidth   = CfgDataWidth,
    parameter int unsigned NumChannels = 3,
    parameter int unsigned GainWidth   = CfgGainWidth,
    parameter int unsigned FracBits    = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic                             in_sof_i,
    input  logic [NumChannels*DataWidth-1:0] in_pix_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic                             out_sof_o,
    output logic [NumChannels*DataWidth-1:0] out_pix_o,
    input  logic                             cfg_we_i,
    input  cfg_t                             cfg_i,
    output logic                             cfg_pending_o
);

    logic s1_valid_q, s1_sof_q, s1_en_q;
    logic s2_valid_q, s2_sof_q;
    cfg_t shadow_q, shadow_d, active_q, active_d;
    logic pending_q, pending_d;

    logic s1_advance, accept, sof_apply, s1_load, s2_load;
    cfg_t cfg_sel;

    assign s1_advance = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s1_advance;
    assign accept     = in_valid_i && in_ready_o;
    assign sof_apply  = accept && in_sof_i;
    // Datapath registers only move with real beats; valids track bubbles.
    assign s1_load    = accept;
    assign s2_load    = s1_advance && s1_valid_q;

    // The sof beat itself must see the promoted shadow, so bypass active_q.
    assign cfg_sel = sof_apply ? shadow_q : active_q;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (sof_apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        // A same-cycle write lands after the promotion and stays pending.
        if (cfg_we_i) begin
            shadow_d  = cfg_i;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_en_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sof_q   <= 1'b0;
            shadow_q   <= CfgDefault;
            active_q   <= CfgDefault;
            pending_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            if (in_ready_o) begin
                s1_valid_q <= in_valid_i;
            end
            if (s1_load) begin
                s1_sof_q <= in_sof_i;
                s1_en_q  <= en_i;
            end
            if (s1_advance) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_load) begin
                s2_sof_q <= s1_sof_q;
            end
        end
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_lane
        contrast_lane #(
            .DataWidth (DataWidth),
            .GainWidth (GainWidth),
            .FracBits  (FracBits)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .s1_load_i (s1_load),
            .s2_load_i (s2_load),
            .en_i      (s1_en_q),
            .x_i       (in_pix_i[c*DataWidth +: DataWidth]),
            .thr1_i    (cfg_sel.thr1),
            .thr2_i    (cfg_sel.thr2),
            .base0_i   (cfg_sel.base0),
            .base1_i   (cfg_sel.base1),
            .base2_i   (cfg_sel.base2),
            .gain0_i   (cfg_sel.gain0),
            .gain1_i   (cfg_sel.gain1),
            .gain2_i   (cfg_sel.gain2),
            .y_o       (out_pix_o[c*DataWidth +: DataWidth])
        );
    end

    assign out_valid_o   = s2_valid_q;
    assign out_sof_o     = s2_sof_q;
    assign cfg_pending_o = pending_q;

endmodule

// File: tb/tb_rgb_contrast_pipe.sv
// Self-checking bench for rgb_contrast_pipe: directed steps plus randomized
// streams compared against a plain-arithmetic model of the transfer curve.
module tb_rgb_contrast_pipe;
    import rgb_contrast_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic [23:0] in_pix = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof;
    logic [23:0] out_pix;
    logic        cfg_we = 1'b0;
    cfg_t        cfg = CfgDefault;
    logic        cfg_pending;

    int n_cmp = 0;
    int n_fail = 0;

    // Model of the configuration state as seen from the interface.
    cfg_t m_shadow = CfgDefault;
    cfg_t m_active = CfgDefault;
    bit   m_pending = 1'b0;

    rgb_contrast_pipe u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_sof_i      (in_sof),
        .in_pix_i      (in_pix),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_sof_o     (out_sof),
        .out_pix_o     (out_pix),
        .cfg_we_i      (cfg_we),
        .cfg_i         (cfg),
        .cfg_pending_o (cfg_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Curve straight from the rules: segment by priority compare, then
    // base + floor(offset * gain / 16), clipped at 255.
    function automatic logic [23:0] ref_pix(input logic [23:0] p, input bit e, input cfg_t c);
        logic [23:0] r;
        int x, t, b, g, y;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            x = int'(p[ch*8 +: 8]);
            if (x < int'(c.thr1)) begin
                t = 0; b = int'(c.base0); g = int'(c.gain0);
            end else if (x < int'(c.thr2)) begin
                t = int'(c.thr1); b = int'(c.base1); g = int'(c.gain1);
            end else begin
                t = int'(c.thr2); b = int'(c.base2); g = int'(c.gain2);
            end
            y = b + ((x - t) * g) / 16;
            if (y > 255) y = 255;
            r[ch*8 +: 8] = e ? 8'(y) : 8'(x);
        end
        return r;
    endfunction

    task automatic write_cfg(input cfg_t c);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg = c;
        @(negedge clk);
        cfg_we = 1'b0;
        m_shadow = c;
        m_pending = 1'b1;
        chk("cfg_pending_set", 64'(cfg_pending), 64'(m_pending));
    endtask

    // One beat on an idle pipe with out_ready=1; checks 2-cycle latency.
    task automatic send_check(input logic [23:0] pix, input bit sof, input bit e,
                              input bit we, input cfg_t wc, input string tag,
                              input bit use_const, input logic [23:0] exp_const);
        cfg_t        used;
        logic [23:0] exp;
        used = sof ? m_shadow : m_active;
        exp  = ref_pix(pix, e, used);
        if (sof) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (we) begin
            m_shadow  = wc;
            m_pending = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b1; in_pix = pix; in_sof = sof; en = e; out_ready = 1'b1;
        cfg_we = we; cfg = wc;
        #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; cfg_we = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        chk({tag, "_lat2_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_pix"}, 64'(out_pix), 64'(exp));
        chk({tag, "_sof"}, 64'(out_sof), 64'(sof));
        if (use_const) chk({tag, "_pix_const"}, 64'(out_pix), 64'(exp_const));
        chk({tag, "_pending"}, 64'(cfg_pending), 64'(m_pending));
    endtask

    // Stream n beats (sof=0); en_mode 0 alternates en, 1 randomizes it.
    task automatic stream(input int n, input bit rand_rdy, input bit en_mode, input string tag);
        logic [23:0] exp_q[$];
        int sent = 0, got = 0, cyc = 0, inflight;
        bit pend = 1'b0;
        while (got < n && cyc < 40 * n + 50) begin
            @(negedge clk);
            cyc++;
            if (!pend && sent < n) begin
                in_valid = 1'b1;
                in_sof = 1'b0;
                in_pix = 24'($urandom);
                en = en_mode ? 1'($urandom_range(0, 1)) : 1'(sent % 2);
                pend = 1'b1;
            end else if (!pend) begin
                in_valid = 1'b0;
            end
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            inflight = sent - got;
            chk({tag, "_in_ready_rule"}, 64'(in_ready), 64'(!(inflight == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_beat"}, 64'(out_valid), 64'(0));
                end else begin
                    chk({tag, "_pix"}, 64'(out_pix), 64'(exp_q.pop_front()));
                    got++;
                end
            end
            if (pend && in_ready) begin
                exp_q.push_back(ref_pix(in_pix, en, m_active));
                sent++;
                pend = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 64'(got), 64'(n));
        @(negedge clk);
        #1 chk({tag, "_drained"}, 64'(out_valid), 64'(0));
    endtask

    cfg_t c_mid, c_sat;

    initial begin
        c_mid = CfgDefault;
        c_mid.base0 = 8'd100;
        c_mid.gain0 = 8'd0;
        c_sat = CfgDefault;
        c_sat.thr1  = 8'd200;
        c_sat.thr2  = 8'd100;
        c_sat.base2 = 8'd250;
        c_sat.gain2 = 8'd255;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_pending", 64'(cfg_pending), 64'(0));
        chk("rst_out_pix", 64'(out_pix), 64'(0));
        chk("rst_out_sof", 64'(out_sof), 64'(0));
        rst = 1'b0;

        // Legacy curve at default configuration
        send_check({8'd85, 8'd84, 8'd0}, 1'b0, 1'b1, 1'b0, CfgDefault, "legacy_a",
                   1'b1, {8'd42, 8'd42, 8'd0});
        send_check({8'd255, 8'd170, 8'd169}, 1'b0, 1'b1, 1'b0, CfgDefault, "legacy_b",
                   1'b1, {8'd255, 8'd213, 8'd210});

        // Bypass
        send_check({8'd99, 8'd200, 8'd17}, 1'b0, 1'b0, 1'b0, CfgDefault, "bypass",
                   1'b1, {8'd99, 8'd200, 8'd17});
        stream(8, 1'b0, 1'b0, "en_toggle");

        // Mid-frame config write: no effect until the next sof beat
        write_cfg(c_mid);
        send_check({8'd10, 8'd10, 8'd10}, 1'b0, 1'b1, 1'b0, CfgDefault, "cfg_hold",
                   1'b1, {8'd5, 8'd5, 8'd5});
        send_check({8'd10, 8'd10, 8'd10}, 1'b1, 1'b1, 1'b0, CfgDefault, "cfg_apply",
                   1'b1, {8'd100, 8'd100, 8'd100});

        // Saturation / inverted thresholds, promoted by a sof beat that
        // coincides with a new write (beat takes the older shadow)
        write_cfg(c_sat);
        send_check({8'd255, 8'd150, 8'd255}, 1'b1, 1'b1, 1'b1, c_mid, "sat_same_cycle",
                   1'b1, {8'd255, 8'd75, 8'd255});
        send_check({8'd10, 8'd199, 8'd100}, 1'b0, 1'b1, 1'b0, CfgDefault, "sat_active",
                   1'b0, 24'd0);
        send_check({8'd10, 8'd10, 8'd10}, 1'b1, 1'b1, 1'b0, CfgDefault, "late_apply",
                   1'b1, {8'd100, 8'd100, 8'd100});

        // Backpressure with random downstream ready
        stream(20, 1'b1, 1'b1, "backpressure");

        // Reset with both stages full and a pending shadow
        write_cfg(c_sat);
        @(negedge clk);
        in_valid = 1'b1; in_sof = 1'b0; en = 1'b1; in_pix = 24'h102030; out_ready = 1'b0;
        @(negedge clk);
        in_pix = 24'h405060;
        @(negedge clk);
        #1;
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("full_out_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_pending", 64'(cfg_pending), 64'(0));
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        m_shadow = CfgDefault; m_active = CfgDefault; m_pending = 1'b0;
        send_check({8'd85, 8'd85, 8'd85}, 1'b0, 1'b1, 1'b0, CfgDefault, "post_rst",
                   1'b1, {8'd42, 8'd42, 8'd42});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
